// File: rtl/clk_chk_pkg.sv
// Shared constants for the 10MHz link clock checker: state encoding,
// default parameter values and the period tolerance helper.
package clk_chk_pkg;

    localparam logic [1:0] NO_CLK  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam int unsigned DEF_CW         = 8;
    localparam int unsigned DEF_NOM_PERIOD = 5;
    localparam int unsigned DEF_PERIOD_TOL = 0;
    localparam int unsigned DEF_LOCK_COUNT = 8;
    localparam int unsigned DEF_TIMEOUT    = 16;
    localparam int unsigned DEF_NOM_HIGH   = 2;

    // True when a measured period lies within nom +/- tol.
    function automatic logic period_ok(input int unsigned cnt,
                                       input int unsigned nom,
                                       input int unsigned tol);
        int unsigned diff;
        diff = (cnt > nom) ? (cnt - nom) : (nom - cnt);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/clk_sync_edge.sv
// Two-flop synchroniser for the incoming link clock, plus a third flop
// holding the previous synchronised sample for rise/fall detection.
module clk_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Resynchronise the asynchronous input and keep one sample of history.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/ten_mhz_clock_checker.sv
// Receive-side checker for the 10MHz link clock. Measures the incoming
// period in 50MHz cycles, declares lock after LOCK_COUNT consecutive good
// periods and reports loss of clock or lock.
// Optional high-time (duty) check: define DUTY_CHECK_EN.
module ten_mhz_clock_checker
    import clk_chk_pkg::*;
#(
    parameter int unsigned CW         = DEF_CW,
    parameter int unsigned NOM_PERIOD = DEF_NOM_PERIOD,
    parameter int unsigned PERIOD_TOL = DEF_PERIOD_TOL,
    parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned NOM_HIGH   = DEF_NOM_HIGH
) (
    input  logic          FiftyMHz_ref_clock,
    input  logic          reset,
    input  logic          TenMHz_input,
    output logic          locked,
    output logic          clk_present,
    output logic          period_valid,
    output logic [CW-1:0] period_out,
    output logic [CW-1:0] high_time,
    output logic          lock_lost,
    output logic [15:0]   error_count
);

    localparam int unsigned   GW         = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(TIMEOUT);
    localparam logic [CW-1:0] NOM_HIGH_V = CW'(NOM_HIGH);
    localparam logic [GW-1:0] LOCK_TGT   = GW'(LOCK_COUNT);

    logic          level, rise, fall;
    logic [CW-1:0] cnt;
    logic [1:0]    state, state_n;
    logic [GW-1:0] good_cnt, good_n;
    logic          timeout, meas_valid, duty_ok, period_good;
    logic          err_inc, lost;

    clk_sync_edge u_sync (
        .clk      (FiftyMHz_ref_clock),
        .reset    (reset),
        .async_in (TenMHz_input),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

`ifdef DUTY_CHECK_EN
    logic [CW-1:0] hcnt;

    // Count synchronised high cycles from each rise; latch the count on fall.
    always_ff @(posedge FiftyMHz_ref_clock) begin
        if (reset) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            if (rise)
                hcnt <= CW'(1);
            else if (level && hcnt != '1)
                hcnt <= hcnt + CW'(1);
            if (fall)
                high_time <= hcnt;
        end
    end

    assign duty_ok = (high_time == NOM_HIGH_V);
`else
    logic unused_sync;
    assign unused_sync = ^{fall, level, NOM_HIGH_V};
    assign high_time   = '0;
    assign duty_ok     = 1'b1;
`endif

    // Classify the period ending at this rise and work out the next state.
    always_comb begin
        timeout     = (cnt == CNT_MAX) && !rise;
        meas_valid  = (state != NO_CLK);
        period_good = period_ok(int'(cnt), NOM_PERIOD, PERIOD_TOL) && duty_ok;
        state_n     = state;
        good_n      = good_cnt;
        err_inc     = 1'b0;
        lost        = 1'b0;
        if (rise) begin
            case (state)
                NO_CLK: begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
                ACQUIRE: begin
                    if (period_good) begin
                        good_n = good_cnt + GW'(1);
                        if (good_n == LOCK_TGT)
                            state_n = LOCKED;
                    end else begin
                        good_n  = '0;
                        err_inc = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!period_good) begin
                        state_n = ACQUIRE;
                        good_n  = '0;
                        err_inc = 1'b1;
                        lost    = 1'b1;
                    end
                end
                default: begin
                    state_n = NO_CLK;
                    good_n  = '0;
                end
            endcase
        end else if (timeout) begin
            state_n = NO_CLK;
            good_n  = '0;
            lost    = (state == LOCKED);
        end
    end

    // Period counter, state register and registered outputs.
    always_ff @(posedge FiftyMHz_ref_clock) begin
        if (reset) begin
            cnt          <= '0;
            state        <= NO_CLK;
            good_cnt     <= '0;
            locked       <= 1'b0;
            clk_present  <= 1'b0;
            period_valid <= 1'b0;
            period_out   <= '0;
            lock_lost    <= 1'b0;
            error_count  <= '0;
        end else begin
            if (rise)
                cnt <= CW'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            state        <= state_n;
            good_cnt     <= good_n;
            // Decoded from the next state so the flags align with the state register.
            locked       <= (state_n == LOCKED);
            clk_present  <= (state_n != NO_CLK);
            period_valid <= rise && meas_valid;
            if (rise && meas_valid)
                period_out <= cnt;
            lock_lost    <= lost;
            if (err_inc && error_count != 16'hFFFF)
                error_count <= error_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ten_mhz_clock_checker.sv
// Bench for ten_mhz_clock_checker: two instances (default tolerance and
// PERIOD_TOL=1) share one stimulus stream and are compared every cycle
// against an edge-index model of the measurement rules.
module tb_ten_mhz_clock_checker;

    localparam int CW      = 8;
    localparam int NOM     = 5;
    localparam int LOCK    = 8;
    localparam int TMO     = 16;
    localparam int NOMHIGH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tin = 1'b0;

    logic          lk0, cp0, pv0, ll0, lk1, cp1, pv1, ll1;
    logic [CW-1:0] po0, ht0, po1, ht1;
    logic [15:0]   ec0, ec1;

    always #10 clk = ~clk;

    ten_mhz_clock_checker dut0 (
        .FiftyMHz_ref_clock(clk), .reset(rst), .TenMHz_input(tin),
        .locked(lk0), .clk_present(cp0), .period_valid(pv0),
        .period_out(po0), .high_time(ht0), .lock_lost(ll0), .error_count(ec0)
    );

    ten_mhz_clock_checker #(.PERIOD_TOL(1)) dut1 (
        .FiftyMHz_ref_clock(clk), .reset(rst), .TenMHz_input(tin),
        .locked(lk1), .clk_present(cp1), .period_valid(pv1),
        .period_out(po1), .high_time(ht1), .lock_lost(ll1), .error_count(ec1)
    );

    // st: 0 none, 1 acquiring, 2 locked. ref_t: edge index at which the
    // period count was last 1 (rise) or reset; h0..h2: last raw samples.
    typedef struct {
        int st; int gc; int err; int ref_t; int last_rise;
        int pout; int ht; bit pv; bit ll; bit h0; bit h1; bit h2;
    } mdl_t;

    mdl_t m0, m1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   ll_seen0 = 0;

    function automatic mdl_t step(input mdl_t m, input bit x, input bit r,
                                  input int tol, input int t);
        mdl_t n;
        bit   rise, fall, good;
        int   c, d;
        n    = m;
        n.pv = 1'b0;
        n.ll = 1'b0;
        if (r) begin
            n = '{default: 0};
            n.ref_t = t + 1;
            return n;
        end
        // A raw sample reaches the edge detector two edges after capture.
        rise = m.h1 & ~m.h2;
        fall = ~m.h1 & m.h2;
        c = t - m.ref_t;
        if (c > TMO) c = TMO;
        if (rise) begin
            if (m.st != 0) begin
                n.pout = c;
                n.pv   = 1'b1;
                d = (c > NOM) ? c - NOM : NOM - c;
                good = (d <= tol);
`ifdef DUTY_CHECK_EN
                good = good && (m.ht == NOMHIGH);
`endif
                if (!good && n.err < 65535) n.err = n.err + 1;
                if (m.st == 1) begin
                    n.gc = good ? m.gc + 1 : 0;
                    if (n.gc == LOCK) n.st = 2;
                end else if (!good) begin
                    n.st = 1; n.gc = 0; n.ll = 1'b1;
                end
            end else begin
                n.st = 1; n.gc = 0;
            end
            n.ref_t = t;
            n.last_rise = t;
        end else if (c == TMO) begin
            if (m.st == 2) n.ll = 1'b1;
            n.st = 0; n.gc = 0;
        end
`ifdef DUTY_CHECK_EN
        if (fall) n.ht = (t - m.last_rise > 255) ? 255 : t - m.last_rise;
`else
        if (fall) n.ht = 0;
`endif
        n.h2 = m.h1; n.h1 = m.h0; n.h0 = x;
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_exp(input mdl_t m);
        return {28'd0, (m.st == 2), (m.st != 0), m.pv, CW'(m.pout), CW'(m.ht), m.ll, 16'(m.err)};
    endfunction

    task automatic tick(input bit x, input bit r);
        @(negedge clk);
        tin = x;
        rst = r;
        @(posedge clk);
        #1;
        cyc++;
        m0 = step(m0, x, r, 0, cyc);
        m1 = step(m1, x, r, 1, cyc);
        check("dut0_outputs", {28'd0, lk0, cp0, pv0, po0, ht0, ll0, ec0}, pack_exp(m0));
        check("dut1_outputs", {28'd0, lk1, cp1, pv1, po1, ht1, ll1, ec1}, pack_exp(m1));
        if (ll0) ll_seen0++;
    endtask

    task automatic periods(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        int len, hi, sel;
        m0 = '{default: 0};
        m1 = '{default: 0};
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("reset_outputs_zero", {lk0, cp0, pv0, po0, ht0, ll0, ec0}, '0);

        // Nominal HHLLL: first period discarded, then eight good ones lock.
        periods(2, 3, 11);
        check("nominal_locked", lk0, 1);
        check("nominal_period", po0, 5);
        check("nominal_errors", ec0, 0);

        // Clock stops while locked.
        ll_seen0 = 0;
        hold_low(20);
        check("timeout_clk_present", cp0, 0);
        check("timeout_locked", lk0, 0);
        check("timeout_lock_lost_pulses", ll_seen0, 1);
        check("timeout_errors", ec0, 0);

        // One long period while locked, then relock.
        periods(2, 3, 11);
        check("relock_before_glitch", lk0, 1);
        ll_seen0 = 0;
        periods(2, 4, 1);
        periods(2, 3, 1);
        check("glitch_lock_lost_pulses", ll_seen0, 1);
        check("glitch_errors", ec0, 1);
        check("glitch_tol1_still_locked", lk1, 1);
        periods(2, 3, 8);
        check("glitch_relocked", lk0, 1);

        // Period exactly at the timeout limit, then one past it.
        periods(1, 15, 2);
        periods(1, 16, 2);

        // Steady 6-cycle period: only the tolerant instance locks.
        tick(1'b0, 1'b1);
        periods(2, 4, 12);
        check("tol1_locked", lk1, 1);
        check("tol1_period", po1, 6);
        check("tol1_errors", ec1, 0);
        check("tol0_not_locked", lk0, 0);

        // Reset mid-acquire.
        periods(2, 3, 3);
        tick(1'b1, 1'b1);
        check("midreset_outputs_zero", {lk0, cp0, pv0, po0, ht0, ll0, ec0}, '0);
        periods(2, 3, 3);

`ifdef DUTY_CHECK_EN
        tick(1'b0, 1'b1);
        periods(3, 2, 10);
        check("duty_high_time", ht0, 3);
        check("duty_not_locked", lk0, 0);
        check("duty_errors", ec0, 9);
`endif

        // Randomised mix of nominal runs, odd periods, dropouts and resets.
        for (int p = 0; p < 400; p++) begin
            sel = $urandom_range(0, 99);
            if (sel < 55) begin
                periods(2, 3, 1);
            end else if (sel < 90) begin
                len = $urandom_range(3, 8);
                hi  = $urandom_range(1, len - 1);
                periods(hi, len - hi, 1);
            end else if (sel < 97) begin
                hold_low($urandom_range(13, 20));
            end else begin
                tick(1'(($urandom_range(0, 1))), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
